pr_frame_ctrl: RTL and testbench

Serial frame controller that sequences running parity detection over a bit-serial input stream. It delimits frames (start bit, DATA_W data bits LSB first, parity bit, stop bit) and accumulates parity over the data bits. It checks the received parity bit and framing, then hands each frame to a downstream consumer through a one-entry valid/ready output buffer. It sits between the serial line sampler and the word-level consumer.

---
 rtl/pr_pkg.sv | 17 +
 rtl/pr_acc.sv | 27 ++
 rtl/pr_frame_ctrl.sv | 131 +++++++++++++
 tb/tb_pr_frame_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pr_pkg.sv
// Shared types and constants for the serial parity frame controller.
package pr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } pr_state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam int PAR_EVEN     = 0;
  localparam int PAR_ODD_MODE = 1;

endpackage

// File: rtl/pr_acc.sv
// One-bit Moore parity accumulator: toggles on each qualified one, clears to EVEN.
module pr_acc
  import pr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic par
);

  logic par_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= EVEN;
    end else if (clr) begin
      par_q <= EVEN;
    end else if (en && bit_in) begin
      par_q <= (par_q == EVEN) ? ODD : EVEN;
    end
  end

  assign par = par_q;

endmodule

// File: rtl/pr_frame_ctrl.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop; each
// finished frame goes into a one-entry valid/ready buffer with error flags.
module pr_frame_ctrl
  import pr_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PAR_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sr_in,
  input  logic              sr_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_err,
  output logic              out_frm_err,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              ovr,
  output logic              busy
);

  localparam int   CNT_W   = $clog2(DATA_W);
  localparam logic ODD_BIT = (PAR_ODD == PAR_ODD_MODE);

  pr_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               perr_q, perr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               operr_q, operr_d;
  logic               oferr_q, oferr_d;
  logic               ovld_q, ovld_d;
  logic               ovr_q, ovr_d;

  logic acc_clr, acc_en, acc_par;
  logic complete, ferr_now, pop, load;

  pr_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .en     (acc_en),
    .bit_in (sr_in),
    .par    (acc_par)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      data_q  <= '0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      ovld_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      data_q  <= data_d;
      operr_q <= operr_d;
      oferr_q <= oferr_d;
      ovld_q  <= ovld_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    complete = 1'b0;
    ferr_now = 1'b0;

    if (sr_vld) begin
      unique case (state_q)
        IDLE: begin
          if (!sr_in) begin
            state_d = DATA;
            cnt_d   = '0;
            acc_clr = 1'b1;
          end
        end
        DATA: begin
          shift_d[cnt_q] = sr_in;
          acc_en         = 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PAR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PAR: begin
          perr_d  = acc_par ^ sr_in ^ ODD_BIT;
          state_d = STOP;
        end
        STOP: begin
          complete = 1'b1;
          ferr_now = ~sr_in;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A pop in the completion cycle frees the slot, so the new frame replaces the old one.
  always_comb begin
    pop     = ovld_q & out_rdy;
    load    = complete & (~ovld_q | pop);
    ovr_d   = complete & ovld_q & ~out_rdy;
    ovld_d  = load | (ovld_q & ~pop);
    data_d  = load ? shift_q  : data_q;
    operr_d = load ? perr_q   : operr_q;
    oferr_d = load ? ferr_now : oferr_q;
  end

  assign out_data    = data_q;
  assign out_par_err = operr_q;
  assign out_frm_err = oferr_q;
  assign out_vld     = ovld_q;
  assign ovr         = ovr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pr_frame_ctrl.sv
// Directed table-driven bench for pr_frame_ctrl, with an even-parity and an
// odd-parity instance sharing one serial stream.
module tb_pr_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       srIn;
  logic       srVld;
  logic       outRdy;

  logic [7:0] outData;
  logic       outPerr, outFerr, outVld, ovr, busy;
  logic [7:0] oddData;
  logic       oddPerr, oddFerr, oddVld, oddOvr, oddBusy;

  int testsRun    = 0;
  int testsFailed = 0;

  logic busyBad;
  logic vldBeforeStop;

  typedef struct {
    logic [7:0] data;
    logic       parBit;
    logic       stopBit;
    logic       expPerr;
    logic       expPerrOdd;
    logic       expFerr;
  } vec_t;

  vec_t vecs[8];

  pr_frame_ctrl #(.DATA_W(8), .PAR_ODD(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .sr_in       (srIn),
    .sr_vld      (srVld),
    .out_data    (outData),
    .out_par_err (outPerr),
    .out_frm_err (outFerr),
    .out_vld     (outVld),
    .out_rdy     (outRdy),
    .ovr         (ovr),
    .busy        (busy)
  );

  pr_frame_ctrl #(.DATA_W(8), .PAR_ODD(1)) dutOdd (
    .clk         (clk),
    .rst         (rst),
    .sr_in       (srIn),
    .sr_vld      (srVld),
    .out_data    (oddData),
    .out_par_err (oddPerr),
    .out_frm_err (oddFerr),
    .out_vld     (oddVld),
    .out_rdy     (outRdy),
    .ovr         (oddOvr),
    .busy        (oddBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time bound so a stuck run still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleCycle();
    srVld = 1'b0;
    srIn  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    srIn  = b;
    srVld = 1'b1;
    @(posedge clk);
    #1;
    srVld = 1'b0;
    srIn  = 1'b1;
  endtask

  // Sends one full frame; returns #1 after the edge that sampled the stop bit.
  task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s,
                               input int gapMax, input logic rdyStop);
    logic [10:0] bits;
    logic        savedRdy;
    bits     = {s, p, d, 1'b0};
    busyBad  = 1'b0;
    savedRdy = outRdy;
    for (int i = 0; i < 11; i++) begin
      if (gapMax > 0 && i > 0) begin
        int g;
        g = $urandom_range(gapMax, 1);
        for (int k = 0; k < g; k++) begin
          idleCycle();
          if (busy !== 1'b1) busyBad = 1'b1;
        end
      end
      if (i == 10) begin
        vldBeforeStop = outVld;
        if (rdyStop) outRdy = 1'b1;
      end
      sendBit(bits[i]);
      if (i == 10 && rdyStop) outRdy = savedRdy;
      if (i < 10 && busy !== 1'b1) busyBad = 1'b1;
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h7E, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst    = 1'b0;
    srIn   = 1'b1;
    srVld  = 1'b0;
    outRdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_vld", 32'(outVld), 32'd0);
    checkOutput("reset out_data", 32'(outData), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ovr/errs", 32'({ovr, outPerr, outFerr}), 32'd0);
    checkOutput("reset odd inst", 32'({oddVld, oddOvr, oddBusy, oddFerr, oddPerr, oddData}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back frames, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].data, vecs[i].parBit, vecs[i].stopBit, 0, 1'b0);
      checkOutput($sformatf("vec%0d vld before stop", i), 32'(vldBeforeStop), 32'd0);
      checkOutput($sformatf("vec%0d out_vld", i), 32'(outVld), 32'd1);
      checkOutput($sformatf("vec%0d out_data", i), 32'(outData), 32'(vecs[i].data));
      checkOutput($sformatf("vec%0d par_err", i), 32'(outPerr), 32'(vecs[i].expPerr));
      checkOutput($sformatf("vec%0d frm_err", i), 32'(outFerr), 32'(vecs[i].expFerr));
      checkOutput($sformatf("vec%0d odd par_err", i), 32'(oddPerr), 32'(vecs[i].expPerrOdd));
      checkOutput($sformatf("vec%0d odd data", i), 32'(oddData), 32'(vecs[i].data));
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
      checkOutput($sformatf("vec%0d ovr", i), 32'(ovr), 32'd0);
    end

    // Overrun: buffer full, consumer stalled.
    idleCycle();
    checkOutput("drain out_vld", 32'(outVld), 32'd0);
    outRdy = 1'b0;
    applyStimulus(8'h11, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("ovr1 out_data", 32'(outData), 32'h11);
    checkOutput("ovr1 ovr", 32'(ovr), 32'd0);
    applyStimulus(8'h22, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("ovr2 ovr pulse", 32'(ovr), 32'd1);
    checkOutput("ovr2 out_data held", 32'(outData), 32'h11);
    checkOutput("ovr2 out_vld", 32'(outVld), 32'd1);
    idleCycle();
    checkOutput("ovr2 ovr one cycle", 32'(ovr), 32'd0);
    checkOutput("ovr2 data still held", 32'(outData), 32'h11);

    // Pop in the completion cycle: replace without overrun.
    applyStimulus(8'h33, 1'b0, 1'b1, 0, 1'b1);
    checkOutput("swap ovr", 32'(ovr), 32'd0);
    checkOutput("swap out_vld", 32'(outVld), 32'd1);
    checkOutput("swap out_data", 32'(outData), 32'h33);
    outRdy = 1'b1;
    idleCycle();
    checkOutput("pop out_vld", 32'(outVld), 32'd0);
    checkOutput("pop data kept", 32'(outData), 32'h33);

    // Idle gaps between every bit.
    applyStimulus(8'h5A, 1'b0, 1'b1, 3, 1'b0);
    outRdy = 1'b0;
    checkOutput("gap out_data", 32'(outData), 32'h5A);
    checkOutput("gap errs", 32'({outPerr, outFerr}), 32'd0);
    checkOutput("gap out_vld", 32'(outVld), 32'd1);
    checkOutput("gap busy throughout", 32'(busyBad), 32'd0);

    // Reset mid-frame after the 4th data bit of 0xFF.
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    checkOutput("midframe busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async rst out_vld", 32'(outVld), 32'd0);
    checkOutput("async rst out_data", 32'(outData), 32'd0);
    checkOutput("async rst busy", 32'(busy), 32'd0);
    checkOutput("async rst flags", 32'({ovr, outPerr, outFerr}), 32'd0);
    @(negedge clk);
    rst    = 1'b1;
    outRdy = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'h0F, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("post rst out_vld", 32'(outVld), 32'd1);
    checkOutput("post rst out_data", 32'(outData), 32'h0F);
    checkOutput("post rst errs", 32'({outPerr, outFerr}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
